// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// mem_arbiter_if : fetch/data request ports and memory-side bus of mem_arbiter
// Rev 1.0
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_data;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rdata;

    logic              err;

    // Arbiter side
    modport slave (
        input  if_req_valid, if_addr,
        input  d_req_valid, d_we, d_addr, d_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data,
        output d_req_ready, d_rsp_valid, d_rsp_data,
        output mem_req_valid, mem_we, mem_addr, mem_wdata,
        output err
    );

    // CPU + memory side
    modport master (
        output if_req_valid, if_addr,
        output d_req_valid, d_we, d_addr, d_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data,
        input  d_req_ready, d_rsp_valid, d_rsp_data,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : single-outstanding arbiter of instruction-fetch and data ports
//               onto one memory port; data priority with fetch starvation bound.
// Rev 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_owner_d;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_err;

    logic              w_fetch_wins;
    logic              w_grant_if;
    logic              w_grant_d;
    logic              w_if_rsp_valid;
    logic              w_d_rsp_valid;

    assign w_fetch_wins = bus.if_req_valid &&
                          (!bus.d_req_valid || (r_starve_cnt == c_STARVE_MAX));

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_if     = 1'b0;
        w_grant_d      = 1'b0;
        w_if_rsp_valid = 1'b0;
        w_d_rsp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fetch_wins) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else if (bus.d_req_valid) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.mem_req_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    w_if_rsp_valid = !r_owner_d;
                    w_d_rsp_valid  = r_owner_d;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fields are captured at grant and held until the next grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else if (w_grant_if) begin
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= bus.if_addr;
            r_wdata   <= '0;
        end else if (w_grant_d) begin
            r_owner_d <= 1'b1;
            r_we      <= bus.d_we;
            r_addr    <= bus.d_addr;
            r_wdata   <= bus.d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_grant_if) begin
            r_starve_cnt <= '0;
        end else if (w_grant_d && bus.if_req_valid) begin
            if (r_starve_cnt != c_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end else if ((r_state == S_IDLE) && !bus.if_req_valid) begin
            r_starve_cnt <= '0;
        end
    end

    // A response with nothing outstanding is a protocol error; sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (bus.mem_rsp_valid && (r_state != S_WAIT)) begin
            r_err <= 1'b1;
        end
    end

    // Readies are gated by rst_n so they read 0 while reset is held
    assign bus.if_req_ready  = w_grant_if & rst_n;
    assign bus.d_req_ready   = w_grant_d & rst_n;
    assign bus.if_rsp_valid  = w_if_rsp_valid;
    assign bus.if_rsp_data   = w_if_rsp_valid ? bus.mem_rdata : '0;
    assign bus.d_rsp_valid   = w_d_rsp_valid;
    assign bus.d_rsp_data    = (w_d_rsp_valid && !r_we) ? bus.mem_rdata : '0;
    assign bus.mem_req_valid = (r_state == S_ISSUE);
    assign bus.mem_we        = r_we;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wdata     = r_wdata;
    assign bus.err           = r_err;

endmodule
`default_nettype wire
